// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_seq_pkg
//  Description : Shared types and constants for the PLL reset sequencer:
//                sequencer state encoding, domain reset bit positions and a
//                helper that identifies states in which domains are live.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_seq_state_t;

    // Bit positions within dom_rst_n
    localparam int DOM_PIX    = 0;   // 25 MHz pixel domain
    localparam int DOM_AUD    = 1;   // 18 MHz audio domain
    localparam int DOM_PIX_SH = 2;   // 25 MHz phase-shifted domain

    // Width of the shared state cycle counter
    localparam int CNT_W = 16;

    // True in states where at least one domain may be out of reset, so a
    // drop of lock there is a lock-loss event rather than a failed attempt.
    function automatic logic domains_live(input pll_seq_state_t s);
        return (s == ST_RELEASE) || (s == ST_RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser bringing an asynchronous level into
//                the clk domain. Both stages clear on asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;

    // Capture the asynchronous input, then re-register to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Brings up a PLL and releases three downstream domain resets
//                in a staggered order once lock has been stable. Retries a
//                failed lock attempt up to MAX_RETRY times, then latches a
//                fault until rst_n or soft_rst. A lock drop while domains
//                are live resets everything and restarts the PLL.
//                Optional feature macro: PLL_SEQ_LOSS_CNT_EN enables the
//                saturating lock-loss event counter on loss_cnt; when it is
//                not defined loss_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int HOLD_CYC   = 16,
    parameter int LOCK_TMO   = 65535,
    parameter int STABLE_CYC = 1024,
    parameter int GAP_CYC    = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic [2:0] dom_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // Counter values at which each timed state acts. The counter reads 0 on
    // the first clock edge after state entry, so "N cycles" ends at N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] AUD_AT      = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] PIX_SH_AT   = CNT_W'(2 * GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_AT      = CNT_W'(2 * GAP_CYC);
    localparam logic [1:0]       RETRY_LIM   = 2'(MAX_RETRY);

    pll_seq_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock_s)
    );

    // Sequencer: state, shared cycle counter and all registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= 3'b000;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 2'd0;
        end else if (soft_rst) begin
            // Restart request overrides every other transition
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= 3'b000;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 2'd0;
        end else if (domains_live(r_state) && !w_lock_s) begin
            // Lock lost with domains live: drop everything and restart the
            // PLL. This is not a failed attempt, so retry_cnt is untouched.
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= 3'b000;
            ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_cnt   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_LIM) begin
                            r_state <= ST_FAULT;
                            fault   <= 1'b1;
                        end else begin
                            r_state   <= ST_HOLD;
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_STABLE: begin
                    if (!w_lock_s) begin
                        // Glitch: back to waiting with a fresh timeout
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state            <= ST_RELEASE;
                        r_cnt              <= '0;
                        dom_rst_n[DOM_PIX] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // Pixel domain was released on entry; the others follow
                    // at GAP_CYC spacing, then one more cycle before RUN.
                    if (r_cnt == RUN_AT) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= '0;
                        ready     <= 1'b1;
                        retry_cnt <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == AUD_AT) begin
                            dom_rst_n[DOM_AUD] <= 1'b1;
                        end
                        if (r_cnt == PIX_SH_AT) begin
                            dom_rst_n[DOM_PIX_SH] <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // Steady state; lock loss is handled above
                    r_cnt <= '0;
                end

                ST_FAULT: begin
                    // Latched until rst_n or soft_rst
                    r_cnt     <= '0;
                    pll_rst   <= 1'b1;
                    dom_rst_n <= 3'b000;
                    fault     <= 1'b1;
                end

                default: begin
                    r_state   <= ST_HOLD;
                    r_cnt     <= '0;
                    pll_rst   <= 1'b1;
                    dom_rst_n <= 3'b000;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic       w_loss_evt;
    logic [7:0] r_loss_cnt;

    // Lock-loss events are counted even when soft_rst wins the transition
    assign w_loss_evt = domains_live(r_state) && !w_lock_s;

    // Saturating lock-loss counter, cleared only by rst_n
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_sequencer
//  Description : Self-checking bench for pll_reset_sequencer. A phase/elapsed
//                reference model predicts every output each cycle; directed
//                scenarios are followed by randomized lock/soft-reset traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int HOLD_CYC   = 4;
    localparam int LOCK_TMO   = 20;
    localparam int STABLE_CYC = 8;
    localparam int GAP_CYC    = 2;
    localparam int MAX_RETRY  = 1;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    // Model phases (bench-local numbering)
    localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst;
    logic       pll_rst;
    logic [2:0] dom_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_reset_sequencer #(
        .HOLD_CYC   (HOLD_CYC),
        .LOCK_TMO   (LOCK_TMO),
        .STABLE_CYC (STABLE_CYC),
        .GAP_CYC    (GAP_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .pll_rst    (pll_rst),
        .dom_rst_n  (dom_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_phase;
    int m_t;        // whole cycles spent in the current phase
    int m_retry;
    int m_loss;
    bit m_pipe[2];  // pll_locked as seen one and two edges ago

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_dom();
        if (m_phase == P_RUN) return 3'b111;
        if (m_phase == P_REL)
            return {m_t >= 2 * GAP_CYC, m_t >= GAP_CYC, 1'b1};
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_phase   = P_HOLD;
        m_t       = 0;
        m_retry   = 0;
        m_loss    = 0;
        m_pipe[0] = 1'b0;
        m_pipe[1] = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_t     = 0;
    endtask

    // Predict the effect of one clock edge given the inputs applied before it
    task automatic model_step(input bit lk, input bit sr);
        bit seen;
        seen      = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = lk;
        if ((m_phase == P_REL || m_phase == P_RUN) && !seen && LOSS_EN && m_loss < 255)
            m_loss++;
        if (sr) begin
            enter(P_HOLD);
            m_retry = 0;
        end else if ((m_phase == P_REL || m_phase == P_RUN) && !seen) begin
            enter(P_HOLD);
        end else begin
            case (m_phase)
                P_HOLD:   if (m_t + 1 >= HOLD_CYC) enter(P_WAIT); else m_t++;
                P_WAIT: begin
                    if (seen) enter(P_STABLE);
                    else if (m_t + 1 >= LOCK_TMO) begin
                        if (m_retry == MAX_RETRY) enter(P_FAULT);
                        else begin m_retry++; enter(P_HOLD); end
                    end else m_t++;
                end
                P_STABLE: begin
                    if (!seen) enter(P_WAIT);
                    else if (m_t + 1 >= STABLE_CYC) enter(P_REL);
                    else m_t++;
                end
                P_REL: begin
                    if (m_t >= 2 * GAP_CYC) begin enter(P_RUN); m_retry = 0; end
                    else m_t++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("pll_rst",   32'(pll_rst),   32'(m_phase == P_HOLD || m_phase == P_FAULT));
        check_eq("dom_rst_n", 32'(dom_rst_n), 32'(m_dom()));
        check_eq("ready",     32'(ready),     32'(m_phase == P_RUN));
        check_eq("fault",     32'(fault),     32'(m_phase == P_FAULT));
        check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        check_eq("loss_cnt",  32'(loss_cnt),  32'(m_loss));
    endtask

    // One clock: apply inputs, advance model, sample on the falling edge
    task automatic tick(input bit lk, input bit sr, input bit rn);
        pll_locked = lk;
        soft_rst   = sr;
        rst_n      = rn;
        if (!rn) model_reset();
        else     model_step(lk, sr);
        @(posedge refclk);
        @(negedge refclk);
        compare_all();
    endtask

    // Leave HOLD with lock low (bounded)
    task automatic wait_hold_done();
        for (int i = 0; i < 40 && pll_rst; i++) tick(1'b0, 1'b0, 1'b1);
        check_eq("hold_exit", 32'(pll_rst), 32'd0);
    endtask

    // Drive lock high until ready (bounded)
    task automatic lock_until_ready(input string tag);
        for (int i = 0; i < 80 && !ready; i++) tick(1'b1, 1'b0, 1'b1);
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        int hl, n, t0, t1, t2;
        bit lvl, rn;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        rst_n      = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        // Asynchronous reset state before any clock edge
        check_eq("rst_pll_rst", 32'(pll_rst),   32'd1);
        check_eq("rst_dom",     32'(dom_rst_n), 32'd0);
        check_eq("rst_ready",   32'(ready),     32'd0);
        @(negedge refclk);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);

        // Normal bring-up: hold length, lock 3 cycles after pll_rst falls, stagger
        tick(1'b0, 1'b0, 1'b1);
        wait_hold_done();
        tick(1'b0, 1'b1, 1'b1);
        hl = 0;
        for (int i = 0; i < 50 && pll_rst; i++) begin hl++; tick(1'b0, 1'b0, 1'b1); end
        check_eq("hold_len", 32'(hl), 32'(HOLD_CYC));
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        t0 = -1; t1 = -1; t2 = -1;
        for (int i = 0; i < 80 && !ready; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (dom_rst_n[0] && t0 < 0) t0 = i;
            if (dom_rst_n[1] && t1 < 0) t1 = i;
            if (dom_rst_n[2] && t2 < 0) t2 = i;
        end
        check_eq("bringup_ready", 32'(ready), 32'd1);
        check_eq("gap_aud",    32'(t1 - t0), 32'(GAP_CYC));
        check_eq("gap_pix_sh", 32'(t2 - t1), 32'(GAP_CYC));

        // Lock glitch during STABLE
        tick(1'b1, 1'b1, 1'b1);
        wait_hold_done();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        lock_until_ready("glitch_ready");
        check_eq("glitch_retry", 32'(retry_cnt), 32'd0);

        // No lock: two timeouts then FAULT; soft_rst clears it
        tick(1'b0, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 200 && !fault; i++) begin n++; tick(1'b0, 1'b0, 1'b1); end
        check_eq("fault_latency", 32'(n), 32'(2 * (HOLD_CYC + LOCK_TMO)));
        check_eq("fault_retry",   32'(retry_cnt), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        check_eq("fault_sticky",  32'(fault), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check_eq("soft_clr_fault", 32'(fault), 32'd0);

        // rst_n asserted mid-RELEASE with only the pixel domain out of reset
        wait_hold_done();
        for (int i = 0; i < 40 && dom_rst_n != 3'b001; i++) tick(1'b1, 1'b0, 1'b1);
        check_eq("rel_dom001", 32'(dom_rst_n), 32'b001);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_dom",   32'(dom_rst_n), 32'd0);
        check_eq("mid_rst_pll",   32'(pll_rst),   32'd1);
        check_eq("mid_rst_retry", 32'(retry_cnt), 32'd0);
        check_eq("mid_rst_loss",  32'(loss_cnt),  32'd0);
        @(negedge refclk);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        wait_hold_done();
        lock_until_ready("post_rst_ready");

        // Loss in RUN, then recovery
        for (int i = 0; i < 10 && ready; i++) tick(1'b0, 1'b0, 1'b1);
        check_eq("loss_ready",  32'(ready),     32'd0);
        check_eq("loss_dom",    32'(dom_rst_n), 32'd0);
        check_eq("loss_count",  32'(loss_cnt),  32'(LOSS_EN ? 1 : 0));
        check_eq("loss_retry",  32'(retry_cnt), 32'd0);
        wait_hold_done();
        lock_until_ready("recover_ready");

        // Randomized lock behaviour with occasional soft and hard resets
        lvl = 1'b1;
        rn  = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if (lvl) lvl = ($urandom_range(0, 59) != 0);
            else     lvl = ($urandom_range(0, 7) == 0);
            if (rn) rn = ($urandom_range(0, 799) != 0);
            else    rn = ($urandom_range(0, 2) == 0);
            tick(lvl, $urandom_range(0, 299) == 0, rn);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
